// File: rtl/ram_sync_clr_if.sv
`default_nettype none
// ============================================================================
// Module : ram_sync_clr_if
// Brief  : Access/clear bus between the CPU core and ram_sync_clr.
// Rev    : 1.0  initial release
// ============================================================================
interface ram_sync_clr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              clr_req;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;

  modport master (
    output ce, we, addr, data_in, clr_req,
    input  data_out, rd_valid, busy
  );

  modport slave (
    input  ce, we, addr, data_in, clr_req,
    output data_out, rd_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/ram_sync_clr.sv
`default_nettype none
// ============================================================================
// Module : ram_sync_clr
// Brief  : Single-port synchronous RAM, registered read, hardware clear engine.
// Rev    : 1.0  initial release
// ============================================================================
module ram_sync_clr #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int RDW_MODE     = 0,
  parameter int CLR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_sync_clr_if.slave   bus
);

  localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t c_rst_state = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  logic [DATA_W-1:0]  r_mem [0:DEPTH-1];
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_idx_w-1:0] r_cnt;
  logic [c_idx_w-1:0] w_cnt_nxt;
  logic [DATA_W-1:0]  r_dout;
  logic [DATA_W-1:0]  w_dout_nxt;
  logic               r_rd_valid;
  logic               w_rd_valid_nxt;
  logic               w_mem_we;
  logic [c_idx_w-1:0] w_mem_idx;
  logic [DATA_W-1:0]  w_mem_wdata;
  logic               w_in_range;
  logic [c_idx_w-1:0] w_addr_idx;
  logic [DATA_W-1:0]  w_rd_word;

  // Addresses at or above DEPTH never touch the array and read back as zero.
  assign w_in_range = ({1'b0, bus.addr} < c_depth);
  assign w_addr_idx = bus.addr[c_idx_w-1:0];
  assign w_rd_word  = w_in_range ? r_mem[w_addr_idx] : '0;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dout_nxt     = r_dout;
    w_rd_valid_nxt = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_idx      = w_addr_idx;
    w_mem_wdata    = bus.data_in;

    case (r_state)
      ST_IDLE: begin
        if (bus.ce) begin
          w_rd_valid_nxt = 1'b1;
          if (bus.we) begin
            w_mem_we   = w_in_range;
            w_dout_nxt = ((RDW_MODE != 0) && w_in_range) ? bus.data_in : w_rd_word;
          end else begin
            w_dout_nxt = w_rd_word;
          end
        end
        if (bus.clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_idx   = r_cnt;
        w_mem_wdata = '0;
        if (r_cnt == c_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_idx_w'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_rst_state;
      r_cnt      <= '0;
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dout     <= w_dout_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  // Array has no reset; writes are blocked while reset is held so an aborted
  // clear leaves the contents exactly as far as it got.
  always_ff @(posedge clk) begin
    if (w_mem_we && rst_n) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  assign bus.data_out = r_dout;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = (r_state == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_ram_sync_clr.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_sync_clr
// Brief  : Scoreboard bench; two DUTs (old-data/auto-clear, new-data/no-clear).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ram_sync_clr;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic              s_ce   = 1'b0;
  logic              s_we   = 1'b0;
  logic [ADDR_W-1:0] s_addr = '0;
  logic [DATA_W-1:0] s_din  = '0;
  logic              s_clr  = 1'b0;

  ram_sync_clr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
  ram_sync_clr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

  assign bus_a.ce = s_ce;  assign bus_a.we = s_we;  assign bus_a.addr = s_addr;
  assign bus_a.data_in = s_din;  assign bus_a.clr_req = s_clr;
  assign bus_b.ce = s_ce;  assign bus_b.we = s_we;  assign bus_b.addr = s_addr;
  assign bus_b.data_in = s_din;  assign bus_b.clr_req = s_clr;

  ram_sync_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                 .RDW_MODE(0), .CLR_ON_RESET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

  ram_sync_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                 .RDW_MODE(1), .CLR_ON_RESET(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  always #5 clk = ~clk;

  // Reference model: index 0 = dut_a, 1 = dut_b
  logic [DATA_W-1:0] m_mem   [2][DEPTH];
  int                m_left  [2] = '{0, 0};
  bit                m_valid [2] = '{0, 0};
  logic [DATA_W-1:0] m_dout  [2] = '{8'h00, 8'h00};
  logic [DATA_W-1:0] q_a [$];
  logic [DATA_W-1:0] q_b [$];

  int n_total = 0;
  int n_pass  = 0;

  function automatic bit cfg_rdw(input int k);
    return (k == 1);
  endfunction

  function automatic bit cfg_clr(input int k);
    return (k == 0);
  endfunction

  task automatic model_reset(input int k);
    m_left[k]  = cfg_clr(k) ? DEPTH : 0;
    m_valid[k] = 1'b0;
    m_dout[k]  = '0;
    if (k == 0) q_a.delete(); else q_b.delete();
  endtask

  task automatic model_step(input int k);
    bit                in_rng;
    logic [DATA_W-1:0] old_w;
    logic [DATA_W-1:0] rsp;
    if (m_left[k] > 0) begin
      m_mem[k][DEPTH - m_left[k]] = '0;
      m_left[k]  = m_left[k] - 1;
      m_valid[k] = 1'b0;
    end else begin
      m_valid[k] = s_ce;
      if (s_ce) begin
        in_rng = (int'(s_addr) < DEPTH);
        old_w  = in_rng ? m_mem[k][int'(s_addr)] : '0;
        rsp    = old_w;
        if (s_we && in_rng) begin
          m_mem[k][int'(s_addr)] = s_din;
          if (cfg_rdw(k)) rsp = s_din;
        end
        m_dout[k] = rsp;
        if (k == 0) q_a.push_back(rsp); else q_b.push_back(rsp);
      end
      if (s_clr) m_left[k] = DEPTH;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) model_reset(k);
        else        model_step(k);
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, k, $time, got, exp);
    else
      n_pass++;
  endtask

  task automatic mon(input int k, input logic busy, input logic rv,
                     input logic [DATA_W-1:0] dout);
    logic [DATA_W-1:0] e;
    chk("busy", k, 32'(busy), 32'(m_left[k] > 0));
    chk("rd_valid", k, 32'(rv), 32'(m_valid[k]));
    if (rv === 1'b1) begin
      if ((k == 0 && q_a.size() == 0) || (k == 1 && q_b.size() == 0)) begin
        chk("unexpected_read", k, 32'(1), 32'(0));
      end else begin
        e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
        chk("read_data", k, 32'(dout), 32'(e));
      end
    end
    chk("data_out_hold", k, 32'(dout), 32'(m_dout[k]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, bus_a.busy, bus_a.rd_valid, bus_a.data_out);
      mon(1, bus_b.busy, bus_b.rd_valid, bus_b.data_out);
    end
  end

  task automatic drive(input bit ce, input bit we, input int addr,
                       input logic [DATA_W-1:0] din, input bit clr);
    @(negedge clk);
    #2;
    s_ce   = ce;
    s_we   = we;
    s_addr = ADDR_W'(addr);
    s_din  = din;
    s_clr  = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    s_ce = 1'b0; s_we = 1'b0; s_clr = 1'b0;
    repeat (hold) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) drive(1, 0, a, 8'h00, 0);
  endtask

  task automatic fill(input logic [DATA_W-1:0] v);
    for (int a = 0; a < DEPTH; a++) drive(1, 1, a, v, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < DEPTH; a++) m_mem[k][a] = '0;

    // Power-up clear on dut_a; dut_b then cleared by request before any read
    do_reset(3);
    idle(14);
    drive(0, 0, 0, 8'h00, 1);
    idle(14);
    read_all();

    // Write then read back, then a ce=0 hold cycle
    drive(1, 1, 3, 8'hA5, 0);
    drive(1, 0, 3, 8'h00, 0);
    idle(2);

    // Read-during-write
    drive(1, 1, 5, 8'h11, 0);
    drive(1, 1, 5, 8'h22, 0);
    drive(1, 0, 5, 8'h00, 0);
    idle(1);

    // Out-of-range write and read
    drive(1, 1, 13, 8'h7E, 0);
    drive(1, 0, 13, 8'h00, 0);
    drive(1, 1, 15, 8'h33, 0);
    drive(1, 0, 1, 8'h00, 0);
    idle(1);

    // Clear with accesses and a second clr_req attempted while busy
    fill(8'hFF);
    drive(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 11; i++)
      drive(1, 1, i, 8'h55, (i == 4));
    idle(3);
    read_all();

    // Reset in the middle of a clear
    fill(8'hFF);
    drive(0, 0, 0, 8'h00, 1);
    idle(5);
    do_reset(2);
    idle(14);
    read_all();

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 15)), DATA_W'($urandom),
            $urandom_range(0, 49) == 0);
    idle(DEPTH + 3);

    chk("queue_drained", 0, 32'(q_a.size()), 32'(0));
    chk("queue_drained", 1, 32'(q_b.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
